// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers, pipeline flush and fixed-latency busy.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops (8-11).
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       MDUOp,
    input  logic             MDUStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Req,
    output logic             Busy,
    output logic [WIDTH-1:0] MDUOut
);

    localparam logic [4:0] OP_MULT  = 5'd0;
    localparam logic [4:0] OP_MULTU = 5'd1;
    localparam logic [4:0] OP_DIV   = 5'd2;
    localparam logic [4:0] OP_DIVU  = 5'd3;
    localparam logic [4:0] OP_MFHI  = 5'd4;
    localparam logic [4:0] OP_MFLO  = 5'd5;
    localparam logic [4:0] OP_MTHI  = 5'd6;
    localparam logic [4:0] OP_MTLO  = 5'd7;
    localparam logic [4:0] OP_MADD  = 5'd8;
    localparam logic [4:0] OP_MADDU = 5'd9;
    localparam logic [4:0] OP_MSUB  = 5'd10;
    localparam logic [4:0] OP_MSUBU = 5'd11;

    localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [4:0]       op_q, op_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic             is_compute, is_div;
    logic             res_wr;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        is_compute = (MDUOp <= OP_DIVU);
`ifdef MDU_MADD_EN
        if (MDUOp >= OP_MADD && MDUOp <= OP_MSUBU) is_compute = 1'b1;
`endif
        is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    end

    // Products sized to 2*WIDTH so the signed/unsigned results need no further extension.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide works on magnitudes; this also yields MIN / -1 = MIN, remainder 0.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quot_u, rem_u, quot, rem;
    assign a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
    assign b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
    assign mag_a  = a_neg ? -a_q : a_q;
    assign mag_b  = b_neg ? -b_q : b_q;
    assign quot_u = mag_a / mag_b;
    assign rem_u  = mag_a % mag_b;
    assign quot   = (a_neg ^ b_neg) ? -quot_u : quot_u;
    assign rem    = a_neg ? -rem_u : rem_u;

`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc;
    always_comb begin
        case (op_q)
            OP_MADD:  acc = {hi_q, lo_q} + prod_s;
            OP_MADDU: acc = {hi_q, lo_q} + prod_u;
            OP_MSUB:  acc = {hi_q, lo_q} - prod_s;
            default:  acc = {hi_q, lo_q} - prod_u;
        endcase
    end
`endif

    always_comb begin
        res_wr = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  begin res_wr = 1'b1; {res_hi, res_lo} = prod_s; end
            OP_MULTU: begin res_wr = 1'b1; {res_hi, res_lo} = prod_u; end
            OP_DIV, OP_DIVU: begin
                // Divide by zero leaves HI/LO untouched.
                res_wr = (b_q != '0);
                res_hi = rem;
                res_lo = quot;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = acc;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            // A flush wins even on the completing edge.
            if (Req) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else if (cnt_q == 8'd1) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (res_wr) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end else if (!Req) begin
            if (MDUStart && is_compute) begin
                a_d    = A;
                b_d    = B;
                op_d   = MDUOp;
                cnt_d  = is_div ? DIV_CNT : MULT_CNT;
                busy_d = 1'b1;
            end else if (MDUOp == OP_MTHI) begin
                hi_d = A;
            end else if (MDUOp == OP_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign Busy   = busy_q;
    assign MDUOut = (MDUOp == OP_MFHI) ? hi_q :
                    (MDUOp == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised and directed bench for mdu_seq against an arithmetic HI/LO reference model.
module tb_mdu_seq;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  MDUOp;
    logic        MDUStart;
    logic [31:0] A, B;
    logic        Req;
    logic        Busy;
    logic [31:0] MDUOut;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .MDUStart(MDUStart),
        .A(A), .B(B), .Req(Req), .Busy(Busy), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int latency(input logic [4:0] op);
        if (op <= 5'd1) return MC;
        if (op == 5'd2 || op == 5'd3) return DC;
`ifdef MDU_MADD_EN
        if (op >= 5'd8 && op <= 5'd11) return MC;
`endif
        return 0;
    endfunction

    task automatic model_apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, q, r;
        logic [63:0] up, acc;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        acc = {m_hi, m_lo};
        case (op)
            5'd0: {m_hi, m_lo} = sp;
            5'd1: {m_hi, m_lo} = up;
            5'd2: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            5'd3: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            5'd6: m_hi = a;
            5'd7: m_lo = a;
            5'd8:  {m_hi, m_lo} = acc + sp;
            5'd9:  {m_hi, m_lo} = acc + up;
            5'd10: {m_hi, m_lo} = acc - sp;
            5'd11: {m_hi, m_lo} = acc - up;
            default: ;
        endcase
    endtask

    // One transaction: issue op, optionally cancel on busy cycle cancel_at (with a colliding
    // start when req_start), optionally poke a start/mthi on busy cycle 2, then check HI/LO.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input bit req_start, input bit poke);
        int  lat = latency(op);
        int  n = 0;
        int  exp_n;
        bit  stale_ok = 1'b1;
        bit  cancelled;
        @(negedge clk);
        MDUOp = op; A = a; B = b; Req = 1'b0;
        MDUStart = (op != 5'd6 && op != 5'd7);
        @(posedge clk); #1;
        MDUStart = 1'b0; MDUOp = 5'd4;
        while (Busy === 1'b1 && n < 400) begin
            #1;
            if (MDUOut !== m_hi) stale_ok = 1'b0;
            @(negedge clk);
            if (n + 1 == cancel_at) begin
                Req = 1'b1;
                if (req_start) begin MDUStart = 1'b1; MDUOp = 5'd1; A = $urandom; end
            end else if (n + 1 == 2 && poke) begin
                MDUStart = 1'b1; MDUOp = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd0; A = $urandom;
            end
            @(posedge clk); #1;
            Req = 1'b0; MDUStart = 1'b0; MDUOp = 5'd4;
            n++;
        end
        cancelled = (cancel_at > 0 && cancel_at <= lat);
        exp_n = cancelled ? cancel_at : lat;
        if (!cancelled && (lat > 0 || op == 5'd6 || op == 5'd7)) model_apply(op, a, b);
        chk("busy_cycles", 64'(n), 64'(exp_n));
        chk("stale_hi", 64'(stale_ok), 64'd1);
        #1 chk("hi", 64'(MDUOut), 64'(m_hi));
        MDUOp = 5'd5;
        #1 chk("lo", 64'(MDUOut), 64'(m_lo));
        MDUOp = 5'd12;
        #1 chk("out_idle", 64'(MDUOut), 64'd0);
        $display("op=%0d a=%h b=%h cancel=%0d busy=%0d hi=%h lo=%h", op, a, b, cancel_at, n, m_hi, m_lo);
    endtask

    logic [4:0] op_tab [12];
    initial begin
        op_tab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd4};
        reset = 1'b1; MDUOp = 5'd12; MDUStart = 1'b0; A = '0; B = '0; Req = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("rst_busy", 64'(Busy), 64'd0);
        MDUOp = 5'd4;
        #1 chk("rst_hi", 64'(MDUOut), 64'd0);
        MDUOp = 5'd5;
        #1 chk("rst_lo", 64'(MDUOut), 64'd0);
        @(negedge clk) reset = 1'b0;

        do_op(5'd0, 32'hFFFFFFFF, 32'h2, 0, 0, 0);
        do_op(5'd3, 32'd7, 32'd2, 0, 0, 0);
        do_op(5'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
        do_op(5'd6, 32'h12345678, 32'd0, 0, 0, 0);
        do_op(5'd2, 32'd99, 32'd0, 0, 0, 0);
        do_op(5'd0, 32'h1234, 32'h5678, 3, 1, 0);
        do_op(5'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
        do_op(5'd6, 32'd0, 32'd0, 0, 0, 0);
        do_op(5'd7, 32'hFFFFFFFF, 32'd0, 0, 0, 0);
        do_op(5'd9, 32'd1, 32'd1, 0, 0, 0);
        do_op(5'd15, 32'hDEADBEEF, 32'd3, 0, 0, 0);
        do_op(5'd1, 32'hCAFEF00D, 32'h87654321, 0, 0, 1);
        do_op(5'd3, 32'd1000, 32'd7, 10, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [4:0]  op;
            logic [31:0] ra, rb;
            int          lat, cancel;
            op = op_tab[$urandom_range(0, 11)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'(signed'($urandom_range(0, 15)) - 8);
                default: ;
            endcase
            lat = latency(op);
            cancel = (lat > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
            do_op(op, ra, rb, cancel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during the 4th busy cycle of a divide.
        @(negedge clk);
        MDUOp = 5'd2; A = 32'd100; B = 32'd7; MDUStart = 1'b1;
        @(posedge clk); #1;
        MDUStart = 1'b0; MDUOp = 5'd4;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("mid_rst_busy", 64'(Busy), 64'd0);
        chk("mid_rst_hi", 64'(MDUOut), 64'd0);
        MDUOp = 5'd5;
        #1 chk("mid_rst_lo", 64'(MDUOut), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) reset = 1'b0;
        do_op(5'd0, 32'hFFFFFFFD, 32'd7, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI, LO and result width in bits.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu/madd-class ops; legal range 1..255.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div/divu; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MDUOp  input  5  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo, 8 madd, 9 maddu, 10 msub, 11 msubu; others no-op.
REQ-007 MDUStart  input  1  start request for compute ops 0-3 and 8-11, sampled on the clock edge.
REQ-008 A  input  WIDTH  operand rs; also data source for mthi/mtlo.
REQ-009 B  input  WIDTH  operand rt.
REQ-010 Req  input  1  flush/cancel from the pipeline (exception or interrupt).
REQ-011 Busy  output  1  registered; high while a compute op is in flight.
REQ-012 MDUOut  output  WIDTH  combinational: HI for mfhi, LO for mflo, else 0.

Function
REQ-013 Edge with MDUStart=1, Busy=0, Req=0, compute op: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from the next cycle.
REQ-014 Counter decrements on each edge while Busy=1; on the edge where the counter equals 1, write the result to HI/LO, clear Busy, and set the counter to 0.
REQ-015 Busy is high for exactly N cycles after the start edge, where N is the op latency; HI/LO change only on the completing edge.
REQ-016 mult: {HI,LO} = signed A*B; multu: unsigned A*B; both are full 2*WIDTH-bit products.
REQ-017 div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend; divu: unsigned quotient and remainder.
REQ-018 Divide by zero (B=0): HI/LO unchanged on completion; Busy timing unchanged.
REQ-019 Signed div of the most-negative value by -1: LO = most-negative value, HI = 0.
REQ-020 mthi/mtlo with Busy=0 and Req=0: write A to HI/LO on the edge; no Busy.
REQ-021 mthi/mtlo with Busy=1: ignored, because the stall logic must prevent this case.
REQ-022 MDUStart while Busy=1: ignored; the in-flight op is unaffected.
REQ-023 Req=1 on any edge: cancel the in-flight op; Busy=0 and counter=0 on the next cycle; HI/LO hold their pre-op values.
REQ-024 Req=1 together with MDUStart or mthi/mtlo on the same edge: the request is dropped.
REQ-025 MDUOut during Busy returns the stale HI/LO; the decoder must stall mf ops while Busy or MDUStart is high.
REQ-026 Ops 12-31 with MDUStart=1: no state change.

Reset
REQ-027 reset=1 asynchronously forces HI=0, LO=0, Busy=0, counter=0 and latched operands/op to 0.
REQ-028 Reset mid-operation aborts the op with no HI/LO update; the first legal start is accepted on the first edge after reset deasserts.

Configuration
REQ-029 Macro MDU_MADD_EN defined: ops 8-11 are compute ops with MULT_CYCLES latency, applied to the 2*WIDTH-bit {HI,LO} value:
- madd: {HI,LO} += signed A*B
- maddu: {HI,LO} += unsigned A*B
- msub: {HI,LO} -= signed A*B
- msubu: {HI,LO} -= unsigned A*B
- Arithmetic is modulo 2^(2*WIDTH).
REQ-030 Macro MDU_MADD_EN undefined: ops 8-11 are no-ops per REQ-026, and no accumulate hardware is synthesised.

Verification
REQ-031 mult with A=0xFFFFFFFF, B=0x00000002 at defaults -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi returns 0xFFFFFFFF.
REQ-032 divu with A=7, B=2, then div with A=0xFFFFFFF9 (-7), B=2 -> divu gives LO=3, HI=1 after 10 busy cycles; div gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 mthi A=0x12345678, then div with B=0 -> HI stays 0x12345678 after 10 busy cycles.
REQ-034 Start mult, Req=1 on the 3rd busy cycle -> Busy low on the next cycle; HI/LO keep prior values; a later MDUStart in the same cycle as Req is ignored.
REQ-035 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro, HI/LO are unchanged and Busy stays low.
REQ-036 Assert reset during the 4th busy cycle of div -> Busy=0, HI=0, LO=0 immediately; a mult issued after reset completes normally.
